// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared FPU arithmetic-path definitions: the iterative square-root FSM state
// encoding, binary32/binary64 format presets and helpers that derive the
// square-root datapath widths from the significand width.
// ---------------------------------------------------------------------------
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } sqrt_state_t;

   // Format presets (significand width includes the hidden bit).
   localparam int B32_SIG_W = 24;
   localparam int B32_EXP_W = 8;
   localparam int B32_LZC_W = 6;
   localparam int B64_SIG_W = 53;
   localparam int B64_EXP_W = 11;
   localparam int B64_LZC_W = 6;

   // Root width: one integer bit, SIG_W-1 fraction bits, guard and round.
   function automatic int sqrt_root_w(input int sig_w);
      return sig_w + 2;
   endfunction

   // Radicand width: twice the root width so floor(sqrt(X)) is ROOT_W bits.
   function automatic int sqrt_rad_w(input int sig_w);
      return 2 * sig_w + 4;
   endfunction

endpackage

// File: rtl/fpu_sqrt_iter_if.sv
// ---------------------------------------------------------------------------
// fpu_sqrt_iter_if
// Request/result bundle of the iterative square-root unit.
//   master : issuer side (unpack stage) - drives start/kill and the operand
//   slave  : the square-root unit      - drives busy/done and the result
// Signals: start, kill, is_subnormal, in_exp0, exp_half[EXP_W], in_sig[SIG_W]
//          busy, done, out_sig[SIG_W+3] = {Q, sticky}, out_exp[EXP_W]
// ---------------------------------------------------------------------------
interface fpu_sqrt_iter_if #(
   parameter int SIG_W = 24,
   parameter int EXP_W = 8
);
   logic             start;
   logic             kill;
   logic             is_subnormal;
   logic             in_exp0;
   logic [EXP_W-1:0] exp_half;
   logic [SIG_W-1:0] in_sig;
   logic             busy;
   logic             done;
   logic [SIG_W+2:0] out_sig;
   logic [EXP_W-1:0] out_exp;

   modport master (
      output start, kill, is_subnormal, in_exp0, exp_half, in_sig,
      input  busy, done, out_sig, out_exp
   );

   modport slave (
      input  start, kill, is_subnormal, in_exp0, exp_half, in_sig,
      output busy, done, out_sig, out_exp
   );
endinterface

// File: rtl/fpu_lzc_param.sv
// ---------------------------------------------------------------------------
// fpu_lzc_param
// Parametrised leading-zero counter.
//   din   [WIDTH] : input vector
//   count [OUT_W] : number of leading zeros; WIDTH when din is all zero
// OUT_W must satisfy 2^OUT_W > WIDTH so the all-zero code is representable.
// ---------------------------------------------------------------------------
module fpu_lzc_param #(
   parameter int WIDTH = 24,
   parameter int OUT_W = 6
) (
   input  logic [WIDTH-1:0] din,
   output logic [OUT_W-1:0] count
);

   // Scanning upward lets the highest set bit make the final assignment.
   always_comb begin
      count = OUT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i]) count = OUT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_sqrt_iter.sv
// ---------------------------------------------------------------------------
// fpu_sqrt_iter
// Iterative radix-2 restoring square root, one root bit per cycle.
// Subnormal operands are normalised before the recurrence, so the returned
// significand is always normalised (Q[SIG_W+1] = 1 for nonzero input).
//   clk, reset : clock, synchronous active-high reset
//   sq (slave) : start/kill request with operand; busy, one-cycle done pulse,
//                out_sig = {Q[SIG_W+1:0], sticky}, out_exp
// Latency from the start cycle: SIG_W+4 cycles, 2 for a zero significand.
// ---------------------------------------------------------------------------
module fpu_sqrt_iter
   import fpu_pkg::*;
#(
   parameter int SIG_W = B32_SIG_W,
   parameter int EXP_W = B32_EXP_W,
   parameter int LZC_W = B32_LZC_W
) (
   input logic             clk,
   input logic             reset,
   fpu_sqrt_iter_if.slave  sq
);

   localparam int ROOT_W = sqrt_root_w(SIG_W);
   localparam int RAD_W  = sqrt_rad_w(SIG_W);
   localparam int REM_W  = SIG_W + 3;
   localparam int CNT_W  = $clog2(ROOT_W);

   sqrt_state_t       state, state_d;
   logic [SIG_W-1:0]  sig_r;
   logic [EXP_W-1:0]  exp_r;
   logic              exp0_r;
   logic              sub_r;
   logic [RAD_W-1:0]  rad_r;
   logic [REM_W-1:0]  rem_r;
   logic [ROOT_W-1:0] q_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              done_r;
   logic [SIG_W+2:0]  osig_r;
   logic [EXP_W-1:0]  oexp_r;

   logic [LZC_W-1:0]  lz;
   logic [LZC_W:0]    lz_inc;
   logic              lz_zero;
   logic              odd;
   logic [SIG_W-1:0]  sig_n;
   logic [EXP_W-1:0]  e_n;
   logic [RAD_W-1:0]  rad_n;
   logic [REM_W+1:0]  rem_sh;
   logic [REM_W+1:0]  trial;
   logic              ge;
   logic [REM_W-1:0]  rem_nx;
   logic [ROOT_W-1:0] q_nx;

   fpu_lzc_param #(.WIDTH(SIG_W), .OUT_W(LZC_W)) u_lzc (
      .din   (sig_r),
      .count (lz)
   );

   // ---- normalisation: radicand and exponent from the latched operand ----
   always_comb begin
      lz_zero = (lz == LZC_W'(SIG_W));
      lz_inc  = {1'b0, lz} + {{LZC_W{1'b0}}, 1'b1};
      if (sub_r) begin
         sig_n = sig_r << lz;
         odd   = lz[0];
         // Each pair of leading zeros removes one from the halved exponent.
         e_n   = exp_r - EXP_W'(lz_inc[LZC_W:1]);
      end else begin
         sig_n = sig_r;
         odd   = ~exp0_r;
         e_n   = exp_r;
      end
      // An odd true exponent is absorbed by one extra radicand shift.
      rad_n = odd ? {sig_n, (SIG_W+4)'(0)} : {1'b0, sig_n, (SIG_W+3)'(0)};
   end

   // ---- recurrence step: two radicand bits in, one root bit out ----
   always_comb begin
      rem_sh = {rem_r, rad_r[RAD_W-1 -: 2]};
      trial  = {1'b0, q_r, 2'b01};
      ge     = (rem_sh >= trial);
      // The kept remainder never exceeds 2Q, so REM_W bits hold it exactly.
      rem_nx = ge ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
      q_nx   = {q_r[ROOT_W-2:0], ge};
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (sq.start) state_d = NORM;
         NORM:    state_d = lz_zero ? DONE : ITER;
         ITER:    if (cnt_r == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (sq.kill) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         sig_r  <= '0;
         exp_r  <= '0;
         exp0_r <= 1'b0;
         sub_r  <= 1'b0;
         rad_r  <= '0;
         rem_r  <= '0;
         q_r    <= '0;
         cnt_r  <= '0;
         done_r <= 1'b0;
         osig_r <= '0;
         oexp_r <= '0;
      end else begin
         state  <= state_d;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (sq.start && !sq.kill) begin
                  sig_r  <= sq.in_sig;
                  exp_r  <= sq.exp_half;
                  exp0_r <= sq.in_exp0;
                  sub_r  <= sq.is_subnormal;
               end
            end
            NORM: begin
               rad_r <= rad_n;
               rem_r <= '0;
               q_r   <= '0;
               cnt_r <= CNT_W'(ROOT_W - 1);
               exp_r <= e_n;
               if (lz_zero && !sq.kill) begin
                  done_r <= 1'b1;
                  osig_r <= '0;
                  oexp_r <= '0;
               end
            end
            ITER: begin
               rad_r <= rad_r << 2;
               rem_r <= rem_nx;
               q_r   <= q_nx;
               cnt_r <= cnt_r - CNT_W'(1);
               // Results are committed on entry to DONE so they are visible
               // in the same cycle as the done pulse.
               if (cnt_r == '0 && !sq.kill) begin
                  done_r <= 1'b1;
                  osig_r <= {q_nx, |rem_nx};
                  oexp_r <= exp_r;
               end
            end
            default: ;
         endcase
      end
   end

   assign sq.busy    = (state != IDLE);
   assign sq.done    = done_r;
   assign sq.out_sig = osig_r;
   assign sq.out_exp = oexp_r;

endmodule

// File: tb/tb_fpu_sqrt_iter.sv
module tb_fpu_sqrt_iter;
   import fpu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fpu_sqrt_iter_if #(.SIG_W(24), .EXP_W(8))  s32 ();
   fpu_sqrt_iter_if #(.SIG_W(53), .EXP_W(11)) s64 ();

   fpu_sqrt_iter #(.SIG_W(24), .EXP_W(8), .LZC_W(6)) dut32 (
      .clk(clk), .reset(reset), .sq(s32.slave)
   );
   fpu_sqrt_iter #(.SIG_W(53), .EXP_W(11), .LZC_W(6)) dut64 (
      .clk(clk), .reset(reset), .sq(s64.slave)
   );

   typedef struct {
      int          dcyc;
      logic [63:0] sig;
      logic [15:0] exp;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic e32, e64;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: normalise, build the radicand, then floor(sqrt) by greedy
   // bit-setting on q*q <= X; sticky is "X is not an exact square".
   function automatic void model(input int sw, input int ew, input logic [63:0] sig,
                                 input logic sub, input logic exp0, input logic [15:0] eh,
                                 output logic [63:0] osig, output logic [15:0] oexp);
      int           lz;
      logic [63:0]  sn;
      logic         odd;
      logic [127:0] x, t, q;
      logic [15:0]  e;
      lz = sw;
      for (int i = 0; i < sw; i++) if (sig[i]) lz = sw - 1 - i;
      if (lz == sw) begin
         osig = '0;
         oexp = '0;
         return;
      end
      if (sub) begin
         sn  = sig << lz;
         odd = lz[0];
         e   = eh - 16'((lz + 1) / 2);
      end else begin
         sn  = sig;
         odd = !exp0;
         e   = eh;
      end
      x = 128'(sn) << (odd ? sw + 4 : sw + 3);
      q = '0;
      for (int b = sw + 1; b >= 0; b--) begin
         t = q | (128'(1) << b);
         if (t * t <= x) q = t;
      end
      osig = 64'((q << 1) | 128'(q * q != x));
      oexp = e & 16'((1 << ew) - 1);
   endfunction

   task automatic drive(input int d, input logic [63:0] sig, input logic sub, input logic e0,
                        input logic [15:0] eh, input int c0);
      exp_t ent;
      int   sw;
      int   ew;
      sw = (d == 0) ? 24 : 53;
      ew = (d == 0) ? 8 : 11;
      model(sw, ew, sig, sub, e0, eh, ent.sig, ent.exp);
      ent.dcyc = c0 + ((sig == 0) ? 2 : sw + 4);
      if (d == 0) begin
         s32.in_sig = sig[23:0]; s32.is_subnormal = sub; s32.in_exp0 = e0;
         s32.exp_half = eh[7:0]; s32.start = 1'b1;
         q32.push_back(ent);
      end else begin
         s64.in_sig = sig[52:0]; s64.is_subnormal = sub; s64.in_exp0 = e0;
         s64.exp_half = eh[10:0]; s64.start = 1'b1;
         q64.push_back(ent);
      end
   endtask

   task automatic launch(input int d, input logic [63:0] sig, input logic sub, input logic e0,
                         input logic [15:0] eh);
      @(posedge clk); #2;
      drive(d, sig, sub, e0, eh, cyc);
      @(posedge clk); #2;
      s32.start = 1'b0;
      s64.start = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n;
      n = 0;
      while (((d == 0) ? q32.size() : q64.size()) != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (n >= 300) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_done%0d: no result after %0d cycles, expected done", d, n);
         q32.delete();
         q64.delete();
      end
   endtask

   // Single compare process: done must be high exactly in the predicted
   // cycle, and the result must match the model when it is.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         e32 = (q32.size() > 0) && (q32[0].dcyc == cyc);
         chk("done32", 64'(s32.done), 64'(e32));
         if (e32) begin
            chk("sig32", 64'(s32.out_sig), q32[0].sig);
            chk("exp32", 64'(s32.out_exp), 64'(q32[0].exp));
            void'(q32.pop_front());
         end
         e64 = (q64.size() > 0) && (q64[0].dcyc == cyc);
         chk("done64", 64'(s64.done), 64'(e64));
         if (e64) begin
            chk("sig64", 64'(s64.out_sig), q64[0].sig);
            chk("exp64", 64'(s64.out_exp), 64'(q64[0].exp));
            void'(q64.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ms;
      logic [15:0] me;
      logic [63:0] mask, sig;
      logic        sub;
      int          sw;

      reset = 1'b1;
      s32.start = 0; s32.kill = 0; s32.is_subnormal = 0; s32.in_exp0 = 0;
      s32.exp_half = '0; s32.in_sig = '0;
      s64.start = 0; s64.kill = 0; s64.is_subnormal = 0; s64.in_exp0 = 0;
      s64.exp_half = '0; s64.in_sig = '0;

      // Pin the model with hand-computed values.
      model(24, 8, 64'h800000, 1'b0, 1'b1, 16'h3F, ms, me);
      chk("model_even_sig", ms, 64'h4000000);
      model(24, 8, 64'h800000, 1'b0, 1'b0, 16'h3F, ms, me);
      chk("model_odd_sig", ms, 64'h5A82799);
      model(24, 8, 64'h1, 1'b1, 1'b0, 16'h20, ms, me);
      chk("model_sub_sig", ms, 64'h5A82799);
      chk("model_sub_exp", 64'(me), 64'h14);
      model(53, 11, 64'h10000000000000, 1'b0, 1'b1, 16'h3FF, ms, me);
      chk("model_b64_sig", ms, 64'h80000000000000);

      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(s32.busy), 64'h0);
      chk("rst_done", 64'(s32.done), 64'h0);
      chk("rst_sig", 64'(s32.out_sig), 64'h0);
      chk("rst_exp", 64'(s32.out_exp), 64'h0);
      chk("rst_busy64", 64'(s64.busy), 64'h0);

      // Even exponent.
      launch(0, 64'h800000, 1'b0, 1'b1, 16'h3F);
      wait_done(0);
      chk("even_sig", 64'(s32.out_sig), 64'h4000000);
      chk("even_exp", 64'(s32.out_exp), 64'h3F);

      // Odd exponent.
      launch(0, 64'h800000, 1'b0, 1'b0, 16'h3F);
      wait_done(0);
      chk("odd_sig", 64'(s32.out_sig), 64'h5A82799);

      // Smallest subnormal.
      launch(0, 64'h1, 1'b1, 1'b0, 16'h20);
      wait_done(0);
      chk("sub_sig", 64'(s32.out_sig), 64'h5A82799);
      chk("sub_exp", 64'(s32.out_exp), 64'h14);

      // Kill in ITER cycle 10: no done, outputs keep the previous result.
      launch(0, 64'hC00000, 1'b0, 1'b1, 16'h40);
      repeat (9) @(posedge clk);
      #2 s32.kill = 1'b1;
      q32.delete();
      @(posedge clk);
      #2 s32.kill = 1'b0;
      @(negedge clk);
      chk("kill_busy", 64'(s32.busy), 64'h0);
      repeat (25) @(negedge clk);
      chk("kill_sig_kept", 64'(s32.out_sig), 64'h5A82799);
      chk("kill_exp_kept", 64'(s32.out_exp), 64'h14);
      launch(0, 64'hC00000, 1'b0, 1'b1, 16'h40);
      wait_done(0);

      // Zero significand: short path, busy only in cycles 1..2.
      launch(0, 64'h0, 1'b1, 1'b0, 16'h55);
      @(negedge clk);
      chk("zero_busy_c1", 64'(s32.busy), 64'h1);
      @(negedge clk);
      chk("zero_busy_c2", 64'(s32.busy), 64'h1);
      @(negedge clk);
      chk("zero_busy_c3", 64'(s32.busy), 64'h0);
      chk("zero_sig", 64'(s32.out_sig), 64'h0);
      chk("zero_exp", 64'(s32.out_exp), 64'h0);
      wait_done(0);

      // start while busy is ignored.
      launch(0, 64'hABCDEF, 1'b0, 1'b1, 16'h10);
      repeat (3) @(posedge clk);
      #2 s32.start = 1'b1;
      s32.in_sig = 24'h900000;
      repeat (3) @(posedge clk);
      #2 s32.start = 1'b0;
      wait_done(0);

      // start raised in the done cycle is only taken in the next IDLE cycle.
      launch(0, 64'hF00000, 1'b0, 1'b0, 16'h22);
      repeat (27) @(posedge clk);
      #2 drive(0, 64'hE12345, 1'b0, 1'b1, 16'h33, cyc + 1);
      @(posedge clk);
      @(posedge clk);
      #2 s32.start = 1'b0;
      wait_done(0);

      // Reset in the middle of ITER.
      launch(0, 64'h812345, 1'b0, 1'b1, 16'h30);
      repeat (5) @(posedge clk);
      #2 reset = 1'b1;
      q32.delete();
      q64.delete();
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(s32.busy), 64'h0);
      chk("midrst_sig", 64'(s32.out_sig), 64'h0);
      chk("midrst_exp", 64'(s32.out_exp), 64'h0);
      repeat (30) @(negedge clk);
      launch(0, 64'h812345, 1'b0, 1'b1, 16'h30);
      wait_done(0);

      // Random regression on both formats.
      for (int d = 0; d < 2; d++) begin
         sw   = (d == 0) ? 24 : 53;
         mask = (64'(1) << sw) - 64'(1);
         for (int n = 0; n < ((d == 0) ? 40 : 20); n++) begin
            sub = ($urandom_range(0, 3) == 0);
            sig = {32'($urandom), 32'($urandom)} & mask;
            if (sub) sig = sig >> $urandom_range(1, sw);
            else     sig = sig | (64'(1) << (sw - 1));
            launch(d, sig, sub, 1'($urandom_range(0, 1)), 16'($urandom));
            wait_done(d);
         end
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
